// File: rtl/digit_scan_driver_if.sv
// Bus bundle for the multiplexed digit scan driver: shadow-load inputs
// from the host side and the segment/digit drive outputs.
interface digit_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   blank_in;
    logic                load;
    logic                lz_sup;
    logic [7:0]          seg_out;
    logic [DIGITS-1:0]   dig_sel;
    logic                scan_tick;

    modport master (
        output data_in, dp_in, blank_in, load, lz_sup,
        input  seg_out, dig_sel, scan_tick
    );

    modport slave (
        input  data_in, dp_in, blank_in, load, lz_sup,
        output seg_out, dig_sel, scan_tick
    );
endinterface

// File: rtl/digit_scan_driver.sv
// Time-multiplexed 7-segment scanner: shadowed digit data, prescaled digit
// rotation, leading-zero suppression and a one-cycle ghost guard per advance.
module digit_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int HEX_EN   = 1
) (
    input logic                clk,
    input logic                rst,
    digit_scan_driver_if.slave bus
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    r_presc;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_data;
    logic [DIGITS-1:0]   r_dp;
    logic [DIGITS-1:0]   r_blank;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_dig_sel;
    logic                r_tick;

    logic                w_tc;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_code_blank;
    logic                w_blank;
    logic                w_supp;
    logic [DIGITS-1:0]   w_lz_mask;
    logic [DIGITS-1:0]   w_dig_on;
    logic [7:0]          w_seg_next;

    // Segment pattern without the dp bit, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] f_seg7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_tc = (r_presc == PRE_LAST);

    // Walk from the top digit down; a nonzero nibble or a lit dp ends suppression.
    always_comb begin
        w_lz_mask = '0;
        w_supp    = bus.lz_sup;
        for (int j = DIGITS - 1; j >= 1; j--) begin
            if ((r_data[4*j +: 4] != 4'h0) || r_dp[j]) begin
                w_supp = 1'b0;
            end
            w_lz_mask[j] = w_supp;
        end
    end

    assign w_nib        = r_data[{r_idx, 2'b00} +: 4];
    assign w_dp         = r_dp[r_idx];
    assign w_code_blank = (HEX_EN == 0) && (w_nib >= 4'd10);
    assign w_blank      = r_blank[r_idx] | w_lz_mask[r_idx] | w_code_blank;
    assign w_seg_next   = w_blank ? 8'hFF : {~w_dp, f_seg7(w_nib)};
    assign w_dig_on     = ~(DIGITS'(1) << r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc   <= '0;
            r_idx     <= '0;
            r_data    <= '0;
            r_dp      <= '0;
            r_blank   <= '0;
            r_seg     <= 8'hFF;
            r_dig_sel <= '1;
            r_tick    <= 1'b0;
        end else begin
            if (bus.load) begin
                r_data  <= bus.data_in;
                r_dp    <= bus.dp_in;
                r_blank <= bus.blank_in;
            end
            if (w_tc) begin
                r_presc <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
            r_tick    <= w_tc;
            r_seg     <= w_seg_next;
            // All digits off during the advance cycle to avoid ghosting.
            r_dig_sel <= w_tc ? '1 : w_dig_on;
        end
    end

    assign bus.seg_out   = r_seg;
    assign bus.dig_sel   = r_dig_sel;
    assign bus.scan_tick = r_tick;

endmodule
